// File: rtl/stopwatch_pkg.sv
// Shared widths, limits and mode encoding for the stopwatch / lap timer.
package stopwatch_pkg;

  localparam int SEC_W   = 6;
  localparam int MIN_W   = 7;
  localparam int SEC_MAX = 59;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  // One lap record, minutes in the upper bits.
  typedef struct packed {
    logic [MIN_W-1:0] min;
    logic [SEC_W-1:0] sec;
  } lap_t;

  localparam int LAP_W = $bits(lap_t);

endpackage

// File: rtl/lap_fifo.sv
// First-word-fall-through FIFO for lap captures; head reads as zero when empty.
module lap_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees a slot in the same cycle, so a push into a full buffer still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/stopwatch_lap_timer.sv
// Up/down mm:ss stopwatch with a one-second prescaler and a lap capture buffer.
module stopwatch_lap_timer
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int MIN_MAX  = 99,
  parameter int N_LAPS   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             mode,
  input  logic             load,
  input  logic [SEC_W-1:0] load_sec,
  input  logic [MIN_W-1:0] load_min,
  input  logic             lap_req,
  input  logic             lap_rd,
  output logic [SEC_W-1:0] seconds,
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] lap_sec,
  output logic [MIN_W-1:0] lap_min,
  output logic             lap_empty,
  output logic             lap_full,
  output logic             lap_ovf,
  output logic             wrap,
  output logic             done
);

  localparam int               PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SEC_W-1:0] SEC_LAST   = SEC_W'(SEC_MAX);
  localparam logic [MIN_W-1:0] MIN_LAST   = MIN_W'(MIN_MAX);

  logic [PW-1:0]    presc;
  logic [PW-1:0]    presc_nxt;
  logic [SEC_W-1:0] sec_nxt;
  logic [MIN_W-1:0] min_nxt;
  logic             wrap_nxt;
  logic             done_nxt;
  logic             tick;
  lap_t             lap_in;
  lap_t             lap_head;

  assign tick = enable && (presc == PRESC_LAST);

  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    presc_nxt = presc;
    sec_nxt   = seconds;
    min_nxt   = minutes;
    wrap_nxt  = 1'b0;
    done_nxt  = 1'b0;
    if (clear) begin
      presc_nxt = '0;
      sec_nxt   = '0;
      min_nxt   = '0;
    end else begin
      if (enable) presc_nxt = tick ? '0 : presc + 1'b1;
      if (load) begin
        presc_nxt = '0;
        sec_nxt   = (load_sec > SEC_LAST) ? SEC_LAST : load_sec;
        min_nxt   = (load_min > MIN_LAST) ? MIN_LAST : load_min;
      end else if (tick) begin
        if (mode == MODE_UP) begin
          if (seconds == SEC_LAST) begin
            sec_nxt = '0;
            if (minutes == MIN_LAST) begin
              min_nxt  = '0;
              wrap_nxt = 1'b1;
            end else begin
              min_nxt = minutes + 1'b1;
            end
          end else begin
            sec_nxt = seconds + 1'b1;
          end
        end else if (seconds != '0) begin
          sec_nxt  = seconds - 1'b1;
          done_nxt = (minutes == '0) && (seconds == SEC_W'(1));
        end else if (minutes != '0) begin
          sec_nxt = SEC_LAST;
          min_nxt = minutes - 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      seconds <= '0;
      minutes <= '0;
      wrap    <= 1'b0;
      done    <= 1'b0;
      lap_ovf <= 1'b0;
    end else begin
      presc   <= presc_nxt;
      seconds <= sec_nxt;
      minutes <= min_nxt;
      wrap    <= wrap_nxt;
      done    <= done_nxt;
      if (clear)                                lap_ovf <= 1'b0;
      else if (lap_req && lap_full && !lap_rd)  lap_ovf <= 1'b1;
    end
  end

  // The capture is the time as it stands before this cycle's update.
  assign lap_in = '{min: minutes, sec: seconds};

  lap_fifo #(
    .DEPTH (N_LAPS),
    .WIDTH (LAP_W)
  ) u_lap_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clear),
    .push  (lap_req),
    .pop   (lap_rd),
    .din   (lap_in),
    .dout  (lap_head),
    .empty (lap_empty),
    .full  (lap_full)
  );

  assign lap_sec = lap_head.sec;
  assign lap_min = lap_head.min;

endmodule
